// File: rtl/cycle_sched.sv
// Phase-slotted two-requester load scheduler with round-robin grant, a fixed-latency
// result tracker and a credit-limited in-order result FIFO.
module cycle_sched #(
  parameter int PHASES  = 4,
  parameter int LATENCY = 12,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  output logic [1:0]  gnt,
  output logic        load,
  output logic        phase_advance,
  output logic [31:0] dout,
  input  logic [31:0] r,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_tag,
  input  logic        res_ready
);
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        tag;
    logic [31:0] data;
  } res_t;

  logic [PW-1:0]    phase;
  logic             ptr, gidx, grant, wr, pop;
  logic [LATENCY:0] vld_pipe, tag_pipe;
  logic [CW-1:0]    outstanding, count;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  res_t             mem [DEPTH];

  // Credit counts in-flight loads plus queued results; a same-cycle pop is not credited.
  always_comb begin
    gnt  = 2'b00;
    gidx = 1'b0;
    if (!rst && phase == '0 && outstanding < CW'(DEPTH)) begin
      case (req)
        2'b01: gnt = 2'b01;
        2'b10: begin gnt = 2'b10; gidx = 1'b1; end
        2'b11: begin gidx = ptr; gnt = ptr ? 2'b10 : 2'b01; end
        default: ;
      endcase
    end
  end

  assign grant     = |gnt;
  assign load      = vld_pipe[0];
  assign wr        = vld_pipe[LATENCY];
  assign res_valid = (count != '0);
  assign pop       = res_valid & res_ready;
  assign res_data  = res_valid ? mem[rd_ptr].data : '0;
  assign res_tag   = res_valid & mem[rd_ptr].tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= '0;
      phase_advance <= 1'b0;
      ptr           <= 1'b0;
      vld_pipe      <= '0;
      tag_pipe      <= '0;
      dout          <= '0;
      outstanding   <= '0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else begin
      phase         <= (phase == PW'(PHASES - 1)) ? '0 : phase + 1'b1;
      phase_advance <= (phase == PW'(PHASES - 1));
      // Stage 0 is the load cycle itself; stage LATENCY lines up with the result on r.
      vld_pipe      <= {vld_pipe[LATENCY-1:0], grant};
      tag_pipe      <= {tag_pipe[LATENCY-1:0], gidx};
      if (grant) begin
        ptr  <= ~gidx;
        dout <= gidx ? din1 : din0;
      end
      case ({grant, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr)  wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= '{tag: tag_pipe[LATENCY], data: r};
  end

endmodule

// File: tb/tb_cycle_sched.sv
// Directed bench for cycle_sched: r carries 0x1000+cycle so each result names the
// cycle it was captured in (grant cycle g -> result 0x1000+g+13).
module tb_cycle_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] din0 = '0, din1 = '0, r = '0;
  logic        res_ready = 1'b0;
  logic [1:0]  gnt;
  logic        load, phase_advance, res_valid, res_tag;
  logic [31:0] dout, res_data;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  cycle_sched #(.PHASES(4), .LATENCY(12), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1), .gnt(gnt),
    .load(load), .phase_advance(phase_advance), .dout(dout), .r(r),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next();
    @(posedge clk); #1;
    cyc++;
    r = 32'h1000 + 32'(cyc);
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with rst low).
  task automatic do_reset();
    rst = 1'b1;
    next(); next();
    rst = 1'b0;
    cyc = 0;
    r   = 32'h1000;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; res_ready = 1'b1;
    next(); next();
    @(negedge clk);
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt got=%b want=00", gnt); end
    tests++; if (load !== 1'b0) begin fails++; $display("FAIL reset_load got=%b want=0", load); end
    tests++; if (phase_advance !== 1'b0) begin fails++; $display("FAIL reset_padv got=%b want=0", phase_advance); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", res_valid); end
    tests++; if (res_tag !== 1'b0) begin fails++; $display("FAIL reset_tag got=%b want=0", res_tag); end
    tests++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_dout got=%h want=0", dout); end
    req = 2'b00;
  endtask

  task automatic test_single();
    req = 2'b01; din0 = 32'hA5A5A5A5; din1 = 32'h5A5A5A5A; res_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      tests++; if (gnt !== ((c % 4 == 0) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL single_gnt c=%0d got=%b", c, gnt); end
      tests++; if (load !== (c % 4 == 1)) begin fails++; $display("FAIL single_load c=%0d got=%b", c, load); end
      if (c % 4 == 1) begin
        tests++; if (dout !== 32'hA5A5A5A5) begin fails++; $display("FAIL single_dout c=%0d got=%h want=a5a5a5a5", c, dout); end
      end
      tests++; if (res_valid !== (c == 14)) begin fails++; $display("FAIL single_valid c=%0d got=%b", c, res_valid); end
      if (c == 14) begin
        tests++; if (res_tag !== 1'b0) begin fails++; $display("FAIL single_tag got=%b want=0", res_tag); end
        tests++; if (res_data !== 32'h100D) begin fails++; $display("FAIL single_data got=%h want=100d", res_data); end
      end
      next();
    end
    req = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'h100D; exp_data[1] = 32'h1011; exp_data[2] = 32'h1015; exp_data[3] = 32'h1019;
    req = 2'b11; din0 = 32'h0000AAAA; din1 = 32'h0000BBBB; res_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 27; c++) begin
      if (c == 13) req = 2'b00;
      @(negedge clk);
      if (c <= 12 && c % 4 == 0) begin
        tests++; if (gnt !== ((c % 8 == 0) ? 2'b01 : 2'b10)) begin fails++; $display("FAIL rr_gnt c=%0d got=%b", c, gnt); end
      end
      if (c == 1 || c == 5) begin
        tests++; if (dout !== ((c == 1) ? 32'h0000AAAA : 32'h0000BBBB)) begin fails++; $display("FAIL rr_dout c=%0d got=%h", c, dout); end
      end
      if (c >= 14 && (c - 14) % 4 == 0) begin
        tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL rr_valid c=%0d got=%b want=1", c, res_valid); end
        tests++; if (res_tag !== 1'((c - 14) / 4 % 2)) begin fails++; $display("FAIL rr_tag c=%0d got=%b", c, res_tag); end
        tests++; if (res_data !== exp_data[(c - 14) / 4]) begin fails++; $display("FAIL rr_data c=%0d got=%h want=%h", c, res_data, exp_data[(c - 14) / 4]); end
      end
      next();
    end
  endtask

  task automatic test_backpressure();
    req = 2'b11; res_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 34; c++) begin
      res_ready = (c == 28);
      if (c == 33) req = 2'b00;
      @(negedge clk);
      if (c <= 12 && c % 4 == 0) begin
        tests++; if (gnt === 2'b00) begin fails++; $display("FAIL bp_grant c=%0d got=00 want=nonzero", c); end
      end
      if (c == 16 || c == 20 || c == 24 || c == 28) begin
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL bp_full_gnt c=%0d got=%b want=00", c, gnt); end
      end
      if (c == 28) begin
        tests++; if (res_valid !== 1'b1 || res_tag !== 1'b0 || res_data !== 32'h100D)
          begin fails++; $display("FAIL bp_head0 got v=%b t=%b d=%h want 1/0/100d", res_valid, res_tag, res_data); end
      end
      if (c == 29) begin
        tests++; if (res_valid !== 1'b1 || res_tag !== 1'b1 || res_data !== 32'h1011)
          begin fails++; $display("FAIL bp_head1 got v=%b t=%b d=%h want 1/1/1011", res_valid, res_tag, res_data); end
      end
      if (c == 32) begin
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL bp_regrant got=%b want=01", gnt); end
      end
      next();
    end
    res_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    req = 2'b01; res_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 21; c++) begin
      if (c == 5) req = 2'b00;
      res_ready = (c == 17 || c == 19);
      @(negedge clk);
      if (c == 14 || c == 17) begin
        tests++; if (res_valid !== 1'b1 || res_data !== 32'h100D)
          begin fails++; $display("FAIL b2b_first c=%0d got v=%b d=%h want 1/100d", c, res_valid, res_data); end
      end
      if (c == 18) begin
        tests++; if (res_valid !== 1'b1 || res_data !== 32'h1011 || res_tag !== 1'b0)
          begin fails++; $display("FAIL b2b_newhead got v=%b d=%h t=%b want 1/1011/0", res_valid, res_data, res_tag); end
      end
      if (c == 20) begin
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL b2b_occupancy got=%b want=0", res_valid); end
      end
      next();
    end
  endtask

  task automatic test_midreset();
    req = 2'b11; res_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) next();
    rst = 1'b1;
    @(negedge clk);
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL mr_gnt_in_rst got=%b want=00", gnt); end
    next();
    rst = 1'b0; req = 2'b00; cyc = 0;
    @(negedge clk);
    tests++; if (load !== 1'b0 || dout !== 32'h0 || phase_advance !== 1'b0 || res_tag !== 1'b0)
      begin fails++; $display("FAIL mr_outputs got l=%b d=%h pa=%b t=%b want 0", load, dout, phase_advance, res_tag); end
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      tests++; if (res_valid !== 1'b0 || load !== 1'b0) begin fails++; $display("FAIL mr_stale c=%0d got v=%b l=%b want 0", c, res_valid, load); end
      tests++; if (phase_advance !== (c % 4 == 0 && c > 0)) begin fails++; $display("FAIL mr_phase c=%0d got=%b", c, phase_advance); end
      next();
    end
  endtask

  task automatic test_idle();
    req = 2'b00;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      tests++; if (load !== 1'b0) begin fails++; $display("FAIL idle_load c=%0d got=%b want=0", c, load); end
      tests++; if (phase_advance !== (c % 4 == 0 && c > 0)) begin fails++; $display("FAIL idle_padv c=%0d got=%b", c, phase_advance); end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_midreset();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
